joystick_adc_sampler: RTL and testbench



---
 rtl/joystick_adc_sampler.sv | 147 ++++++++++++++
 tb/tb_joystick_adc_sampler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_adc_sampler.sv
// XADC DRP master for the joystick: after each end-of-conversion it reads the X and Y
// auxiliary channels and publishes them together as one coherent 12-bit pair.
module joystick_adc_sampler #(
    parameter logic [6:0]  X_ADDR  = 7'h16,
    parameter logic [6:0]  Y_ADDR  = 7'h1E,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eoc,
    output logic        den,
    output logic [6:0]  daddr,
    output logic        dwe,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [11:0] adc_x_value,
    output logic [11:0] adc_y_value,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_X,
        S_WAIT_X,
        S_REQ_Y,
        S_WAIT_Y,
        S_UPDATE
    } state_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]   x_tmp_q, x_tmp_d;
    logic [DATA_W-1:0]   adc_x_d, adc_y_d;
    logic                den_d, sample_valid_d, busy_d, timeout_err_d;
    logic [ADDR_W-1:0]   daddr_d;
    logic                unused_nibble;

    // The low nibble of the DRP word carries no sample data.
    assign unused_nibble = ^do_in[3:0];
    assign dwe = 1'b0;

    // Next-state, capture and timeout decisions; outputs are decoded from the next state
    // so the registered outputs line up with the state they describe.
    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        cnt_d         = cnt_q;
        x_tmp_d       = x_tmp_q;
        adc_x_d       = adc_x_value;
        adc_y_d       = adc_y_value;
        timeout_err_d = timeout_err;
        cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

        if (eoc && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (eoc || pending_q) begin
                    state_d   = S_REQ_X;
                    pending_d = 1'b0;
                end
            end
            S_REQ_X: begin
                state_d = S_WAIT_X;
                cnt_d   = '0;
            end
            S_WAIT_X: begin
                cnt_d = cnt_inc;
                if (drdy) begin
                    x_tmp_d = do_in[15:4];
                    state_d = S_REQ_Y;
                end else if (cnt_inc == CNT_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_REQ_Y: begin
                state_d = S_WAIT_Y;
                cnt_d   = '0;
            end
            S_WAIT_Y: begin
                cnt_d = cnt_inc;
                if (drdy) begin
                    // Publish the pair on entry to UPDATE so it appears with sample_valid.
                    adc_x_d = x_tmp_q;
                    adc_y_d = do_in[15:4];
                    state_d = S_UPDATE;
                end else if (cnt_inc == CNT_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        den_d          = (state_d == S_REQ_X) || (state_d == S_REQ_Y);
        daddr_d        = (state_d == S_REQ_X) ? X_ADDR :
                         (state_d == S_REQ_Y) ? Y_ADDR : '0;
        busy_d         = (state_d != S_IDLE);
        sample_valid_d = (state_d == S_UPDATE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            cnt_q        <= '0;
            x_tmp_q      <= '0;
            den          <= 1'b0;
            daddr        <= '0;
            adc_x_value  <= '0;
            adc_y_value  <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            x_tmp_q      <= x_tmp_d;
            den          <= den_d;
            daddr        <= daddr_d;
            adc_x_value  <= adc_x_d;
            adc_y_value  <= adc_y_d;
            sample_valid <= sample_valid_d;
            busy         <= busy_d;
            timeout_err  <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_joystick_adc_sampler.sv
// Directed bench for joystick_adc_sampler: instance A uses the default timeout,
// instance B uses TIMEOUT=16; sel routes the stimulus and observation to one of them.
module tb_joystick_adc_sampler;

    logic        clk;
    logic        reset;
    logic        eoc;
    logic        drdy;
    logic [15:0] do_in;
    logic        sel;

    logic        a_eoc, a_drdy, b_eoc, b_drdy;
    logic        a_den, a_dwe, a_sv, a_busy, a_terr;
    logic        b_den, b_dwe, b_sv, b_busy, b_terr;
    logic [6:0]  a_daddr, b_daddr;
    logic [11:0] a_x, a_y, b_x, b_y;

    logic        den, dwe, sv, busy, terr;
    logic [6:0]  daddr;
    logic [11:0] x, y;

    int checks;
    int errors;

    assign a_eoc  = sel ? 1'b0 : eoc;
    assign a_drdy = sel ? 1'b0 : drdy;
    assign b_eoc  = sel ? eoc  : 1'b0;
    assign b_drdy = sel ? drdy : 1'b0;

    assign den   = sel ? b_den   : a_den;
    assign dwe   = sel ? b_dwe   : a_dwe;
    assign sv    = sel ? b_sv    : a_sv;
    assign busy  = sel ? b_busy  : a_busy;
    assign terr  = sel ? b_terr  : a_terr;
    assign daddr = sel ? b_daddr : a_daddr;
    assign x     = sel ? b_x     : a_x;
    assign y     = sel ? b_y     : a_y;

    joystick_adc_sampler #(.X_ADDR(7'h16), .Y_ADDR(7'h1E), .TIMEOUT(255)) dut_a (
        .clk(clk), .reset(reset), .eoc(a_eoc), .den(a_den), .daddr(a_daddr), .dwe(a_dwe),
        .drdy(a_drdy), .do_in(do_in), .adc_x_value(a_x), .adc_y_value(a_y),
        .sample_valid(a_sv), .busy(a_busy), .timeout_err(a_terr)
    );

    joystick_adc_sampler #(.X_ADDR(7'h16), .Y_ADDR(7'h1E), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .eoc(b_eoc), .den(b_den), .daddr(b_daddr), .dwe(b_dwe),
        .drdy(b_drdy), .do_in(do_in), .adc_x_value(b_x), .adc_y_value(b_y),
        .sample_valid(b_sv), .busy(b_busy), .timeout_err(b_terr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eoc();
        eoc = 1'b1;
        step();
        eoc = 1'b0;
    endtask

    // Called in the den cycle: answer the read after 'delay' idle wait cycles.
    task automatic drp_respond(input logic [15:0] data, input int delay);
        step();
        repeat (delay) step();
        drdy  = 1'b1;
        do_in = data;
        step();
        drdy  = 1'b0;
        do_in = 16'h0000;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({den, daddr, dwe, sv, busy, terr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_ctrl: got den=%0b daddr=%h dwe=%0b sv=%0b busy=%0b terr=%0b expected all 0",
                     den, daddr, dwe, sv, busy, terr);
        end
        checks++;
        if ({x, y} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_pair: got x=%h y=%h expected 000/000", x, y);
        end
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || den !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%0b den=%0b expected 0/0", busy, den);
        end
    endtask

    task automatic test_basic();
        pulse_eoc();
        checks++;
        if (den !== 1'b1 || daddr !== 7'h16 || busy !== 1'b1 || dwe !== 1'b0) begin
            errors++;
            $display("FAIL basic_req_x: got den=%0b daddr=%h busy=%0b dwe=%0b expected 1/16/1/0",
                     den, daddr, busy, dwe);
        end
        drp_respond(16'hABC0, 0);
        checks++;
        if (den !== 1'b1 || daddr !== 7'h1E || sv !== 1'b0) begin
            errors++;
            $display("FAIL basic_req_y: got den=%0b daddr=%h sv=%0b expected 1/1e/0", den, daddr, sv);
        end
        drp_respond(16'h1230, 0);
        checks++;
        if (sv !== 1'b1 || x !== 12'hABC || y !== 12'h123) begin
            errors++;
            $display("FAIL basic_update: got sv=%0b x=%h y=%h expected 1/abc/123", sv, x, y);
        end
        step();
        checks++;
        if (sv !== 1'b0 || busy !== 1'b0 || den !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: got sv=%0b busy=%0b den=%0b expected 0/0/0", sv, busy, den);
        end
    endtask

    task automatic test_coherency();
        pulse_eoc();
        drp_respond(16'h5550, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (x !== 12'hABC || y !== 12'h123 || sv !== 1'b0) begin
                errors++;
                $display("FAIL coherency_hold[%0d]: got x=%h y=%h sv=%0b expected abc/123/0", i, x, y, sv);
            end
            step();
        end
        drdy  = 1'b1;
        do_in = 16'h6660;
        step();
        drdy  = 1'b0;
        do_in = 16'h0000;
        checks++;
        if (x !== 12'h555 || y !== 12'h666 || sv !== 1'b1) begin
            errors++;
            $display("FAIL coherency_update: got x=%h y=%h sv=%0b expected 555/666/1", x, y, sv);
        end
        step();
    endtask

    task automatic test_stray_drdy();
        drdy  = 1'b1;
        do_in = 16'hFFF0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || den !== 1'b0 || sv !== 1'b0 || x !== 12'h555 || y !== 12'h666) begin
                errors++;
                $display("FAIL stray_drdy[%0d]: got busy=%0b den=%0b sv=%0b x=%h y=%h expected 0/0/0/555/666",
                         i, busy, den, sv, x, y);
            end
        end
        drdy  = 1'b0;
        do_in = 16'h0000;
        step();
    endtask

    task automatic test_pending();
        pulse_eoc();
        pulse_eoc();
        pulse_eoc();
        drdy  = 1'b1;
        do_in = 16'h3210;
        step();
        drdy  = 1'b0;
        pulse_eoc();
        drdy  = 1'b1;
        do_in = 16'h4560;
        step();
        drdy  = 1'b0;
        do_in = 16'h0000;
        checks++;
        if (sv !== 1'b1 || x !== 12'h321 || y !== 12'h456) begin
            errors++;
            $display("FAIL pending_first: got sv=%0b x=%h y=%h expected 1/321/456", sv, x, y);
        end
        step();
        checks++;
        if (busy !== 1'b0 || den !== 1'b0 || sv !== 1'b0) begin
            errors++;
            $display("FAIL pending_idle: got busy=%0b den=%0b sv=%0b expected 0/0/0", busy, den, sv);
        end
        step();
        checks++;
        if (den !== 1'b1 || daddr !== 7'h16 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pending_restart: got den=%0b daddr=%h busy=%0b expected 1/16/1", den, daddr, busy);
        end
        drp_respond(16'h7770, 0);
        drp_respond(16'h8880, 0);
        checks++;
        if (sv !== 1'b1 || x !== 12'h777 || y !== 12'h888) begin
            errors++;
            $display("FAIL pending_second: got sv=%0b x=%h y=%h expected 1/777/888", sv, x, y);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || den !== 1'b0 || sv !== 1'b0) begin
                errors++;
                $display("FAIL pending_no_third[%0d]: got busy=%0b den=%0b sv=%0b expected 0/0/0",
                         i, busy, den, sv);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        pulse_eoc();
        drp_respond(16'h1110, 0);
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({den, daddr, dwe, sv, busy, terr} !== 12'h000 || {x, y} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_mid_async: got den=%0b daddr=%h sv=%0b busy=%0b terr=%0b x=%h y=%h expected all 0",
                     den, daddr, sv, busy, terr, x, y);
        end
        step();
        step();
        reset = 1'b1;
        drdy  = 1'b1;
        do_in = 16'hFFF0;
        step();
        drdy  = 1'b0;
        do_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sv !== 1'b0 || busy !== 1'b0 || den !== 1'b0 || {x, y} !== 24'h000000) begin
                errors++;
                $display("FAIL reset_mid_late_drdy[%0d]: got sv=%0b busy=%0b den=%0b x=%h y=%h expected 0/0/0/000/000",
                         i, sv, busy, den, x, y);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        sel = 1'b1;
        step();
        // drdy on the 15th wait cycle beats the limit
        pulse_eoc();
        drp_respond(16'h9870, 0);
        drp_respond(16'h6540, 14);
        checks++;
        if (sv !== 1'b1 || x !== 12'h987 || y !== 12'h654 || terr !== 1'b0) begin
            errors++;
            $display("FAIL timeout_edge: got sv=%0b x=%h y=%h terr=%0b expected 1/987/654/0", sv, x, y, terr);
        end
        step();
        pulse_eoc();
        drp_respond(16'h1110, 0);
        step();
        for (int i = 1; i <= 15; i++) begin
            checks++;
            if (busy !== 1'b1 || terr !== 1'b0 || sv !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got busy=%0b terr=%0b sv=%0b expected 1/0/0", i, busy, terr, sv);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || terr !== 1'b1 || sv !== 1'b0 || x !== 12'h987 || y !== 12'h654) begin
            errors++;
            $display("FAIL timeout_abort: got busy=%0b terr=%0b sv=%0b x=%h y=%h expected 0/1/0/987/654",
                     busy, terr, sv, x, y);
        end
        step();
        checks++;
        if (busy !== 1'b0 || den !== 1'b0) begin
            errors++;
            $display("FAIL timeout_stays_idle: got busy=%0b den=%0b expected 0/0", busy, den);
        end
        pulse_eoc();
        checks++;
        if (den !== 1'b1 || daddr !== 7'h16) begin
            errors++;
            $display("FAIL timeout_next_req: got den=%0b daddr=%h expected 1/16", den, daddr);
        end
        drp_respond(16'h2220, 0);
        drp_respond(16'h3330, 0);
        checks++;
        if (sv !== 1'b1 || x !== 12'h222 || y !== 12'h333 || terr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_recover: got sv=%0b x=%h y=%h terr=%0b expected 1/222/333/1", sv, x, y, terr);
        end
        step();
        sel = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        eoc    = 1'b0;
        drdy   = 1'b0;
        do_in  = 16'h0000;
        sel    = 1'b0;
        test_reset();
        test_basic();
        test_coherency();
        test_stray_drdy();
        test_pending();
        test_reset_mid_sweep();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
